// File: rtl/drive_pkg.sv
// rtl/drive_pkg.sv - drive command codes, sequencer states, duty constants and helpers
package drive_pkg;

  typedef enum logic [2:0] {
    DRV_STOP   = 3'b000,
    DRV_LEFT   = 3'b001,
    DRV_RIGHT  = 3'b010,
    DRV_SLOW   = 3'b011,
    DRV_MEDIUM = 3'b100,
    DRV_FAST   = 3'b101
  } drive_state_t;

  typedef enum logic [1:0] {
    SEQ_RUN   = 2'b00,
    SEQ_BRAKE = 2'b01,
    SEQ_DEAD  = 2'b10
  } seq_state_t;

  localparam logic [7:0] DUTY_TURN = 8'd96;
  localparam logic [7:0] DUTY_SLOW = 8'd64;
  localparam logic [7:0] DUTY_MED  = 8'd128;
  localparam logic [7:0] DUTY_FAST = 8'd192;

  typedef struct packed {
    logic       l_dir;
    logic [7:0] l_duty;
    logic       r_dir;
    logic [7:0] r_duty;
  } motor_tgt_t;

  // STOP and the unused codes keep the present directions so they never trigger a reversal
  function automatic motor_tgt_t decode_cmd(input logic [2:0] cmd, input logic cur_l_dir,
                                            input logic cur_r_dir);
    motor_tgt_t t;
    t = '{cur_l_dir, 8'd0, cur_r_dir, 8'd0};
    case (cmd)
      DRV_LEFT:   t = '{1'b0, DUTY_TURN, 1'b1, DUTY_TURN};
      DRV_RIGHT:  t = '{1'b1, DUTY_TURN, 1'b0, DUTY_TURN};
      DRV_SLOW:   t = '{1'b1, DUTY_SLOW, 1'b1, DUTY_SLOW};
      DRV_MEDIUM: t = '{1'b1, DUTY_MED, 1'b1, DUTY_MED};
      DRV_FAST:   t = '{1'b1, DUTY_FAST, 1'b1, DUTY_FAST};
      default:    t = '{cur_l_dir, 8'd0, cur_r_dir, 8'd0};
    endcase
    return t;
  endfunction

  function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] goal,
                                             input logic [7:0] step);
    logic [7:0] nxt;
    nxt = cur;
    if (goal > cur) begin
      nxt = (goal - cur > step) ? cur + step : goal;
    end else if (goal < cur) begin
      nxt = (cur - goal > step) ? cur - step : goal;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - prescaled 8-bit PWM counter with registered compare output
module pwm_gen #(
  parameter int PRESCALE = 4
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [7:0] duty,
  input  logic       force_off,
  output logic       pwm
);

  logic [15:0] presc_cnt;
  logic [7:0]  cnt;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      presc_cnt <= '0;
      cnt       <= '0;
      pwm       <= 1'b0;
    end else begin
      pwm <= !force_off && (cnt < duty);
      if (presc_cnt == 16'(PRESCALE - 1)) begin
        presc_cnt <= '0;
        cnt       <= cnt + 8'd1;
      end else begin
        presc_cnt <= presc_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/motor_drive_sequencer.sv
// rtl/motor_drive_sequencer.sv - ramped duty, brake/dead-time reversal sequencing for two H-bridges
module motor_drive_sequencer
  import drive_pkg::*;
#(
  parameter int PRESCALE  = 4,
  parameter int RAMP_TICK = 50000,
  parameter int RAMP_STEP = 8,
  parameter int DEADTIME  = 50000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [2:0] drive_state,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic       left_dir,
  output logic       right_dir,
  output logic [7:0] left_duty,
  output logic [7:0] right_duty,
  output logic [1:0] seq_state,
  output logic       settled
);

  logic [2:0]  cmd_q;
  seq_state_t  state, state_nxt;
  logic [31:0] tick_cnt, dead_cnt, dead_nxt;
  logic        tick, l_mis, r_mis, mismatch, zero_tgt, latch_dirs;
  motor_tgt_t  tgt;
  logic [7:0]  l_goal, r_goal;

  assign tgt      = decode_cmd(cmd_q, left_dir, right_dir);
  assign l_mis    = (tgt.l_dir != left_dir) && (tgt.l_duty != 8'd0);
  assign r_mis    = (tgt.r_dir != right_dir) && (tgt.r_duty != 8'd0);
  assign mismatch = l_mis || r_mis;
  assign tick     = (tick_cnt == 32'(RAMP_TICK - 1));
  assign l_goal   = zero_tgt ? 8'd0 : tgt.l_duty;
  assign r_goal   = zero_tgt ? 8'd0 : tgt.r_duty;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state    <= SEQ_RUN;
      dead_cnt <= '0;
    end else begin
      state    <= state_nxt;
      dead_cnt <= dead_nxt;
    end
  end

  // A pending reversal already counts as braking so a ramp tick never pushes the wrong way
  always_comb begin
    state_nxt  = state;
    dead_nxt   = dead_cnt;
    zero_tgt   = 1'b0;
    latch_dirs = 1'b0;
    case (state)
      SEQ_RUN: begin
        if (mismatch) begin
          state_nxt = SEQ_BRAKE;
          zero_tgt  = 1'b1;
        end
      end
      SEQ_BRAKE: begin
        zero_tgt = 1'b1;
        if (!mismatch) begin
          state_nxt = SEQ_RUN;
        end else if (left_duty == 8'd0 && right_duty == 8'd0) begin
          state_nxt = SEQ_DEAD;
          dead_nxt  = 32'(DEADTIME - 1);
        end
      end
      SEQ_DEAD: begin
        zero_tgt = 1'b1;
        if (dead_cnt == 32'd0) begin
          state_nxt  = SEQ_RUN;
          latch_dirs = 1'b1;
        end else begin
          dead_nxt = dead_cnt - 32'd1;
        end
      end
      default: state_nxt = SEQ_RUN;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      cmd_q      <= DRV_STOP;
      tick_cnt   <= '0;
      left_duty  <= '0;
      right_duty <= '0;
      left_dir   <= 1'b1;
      right_dir  <= 1'b1;
    end else begin
      cmd_q    <= drive_state;
      tick_cnt <= tick ? '0 : tick_cnt + 32'd1;
      if (tick) begin
        left_duty  <= ramp_toward(left_duty, l_goal, 8'(RAMP_STEP));
        right_duty <= ramp_toward(right_duty, r_goal, 8'(RAMP_STEP));
      end
      if (latch_dirs) begin
        left_dir  <= tgt.l_dir;
        right_dir <= tgt.r_dir;
      end
    end
  end

  assign seq_state = state;
  assign settled   = (state == SEQ_RUN) && (left_duty == tgt.l_duty) && (right_duty == tgt.r_duty)
                     && (left_dir == tgt.l_dir) && (right_dir == tgt.r_dir);

  pwm_gen #(.PRESCALE(PRESCALE)) u_pwm_left (
    .clk_50    (clk_50),
    .reset     (reset),
    .duty      (left_duty),
    .force_off (state == SEQ_DEAD),
    .pwm       (left_pwm)
  );

  pwm_gen #(.PRESCALE(PRESCALE)) u_pwm_right (
    .clk_50    (clk_50),
    .reset     (reset),
    .duty      (right_duty),
    .force_off (state == SEQ_DEAD),
    .pwm       (right_pwm)
  );

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// tb/tb_motor_drive_sequencer.sv - self-checking bench with cycle-level behavioural model
module tb_motor_drive_sequencer;

  localparam int PRESCALE  = 1;
  localparam int RAMP_TICK = 4;
  localparam int RAMP_STEP = 16;
  localparam int DEADTIME  = 8;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] drive_state = 3'b000;
  logic       left_pwm, right_pwm, left_dir, right_dir, settled;
  logic [7:0] left_duty, right_duty;
  logic [1:0] seq_state;

  always #10 clk_50 = ~clk_50;

  motor_drive_sequencer #(
    .PRESCALE  (PRESCALE),
    .RAMP_TICK (RAMP_TICK),
    .RAMP_STEP (RAMP_STEP),
    .DEADTIME  (DEADTIME)
  ) dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .drive_state (drive_state),
    .left_pwm    (left_pwm),
    .right_pwm   (right_pwm),
    .left_dir    (left_dir),
    .right_dir   (right_dir),
    .left_duty   (left_duty),
    .right_duty  (right_duty),
    .seq_state   (seq_state),
    .settled     (settled)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0h, required %0h", name, act, exp);
  endtask

  // Reference: command table and reversal rules in plain integer arithmetic
  int m_k, m_phase, m_cmd, m_ldir, m_rdir, m_lduty, m_rduty, m_lpwm, m_rpwm, m_dead_left, m_settled;
  bit m_valid = 1'b0;
  bit m_reset_edge = 1'b0;

  function automatic void target_of(input int cmd, input int cur_l, input int cur_r,
                                    output int ld, output int lv, output int rd, output int rv);
    ld = cur_l; rd = cur_r; lv = 0; rv = 0;
    case (cmd)
      1: begin ld = 0; lv = 96;  rd = 1; rv = 96;  end
      2: begin ld = 1; lv = 96;  rd = 0; rv = 96;  end
      3: begin ld = 1; lv = 64;  rd = 1; rv = 64;  end
      4: begin ld = 1; lv = 128; rd = 1; rv = 128; end
      5: begin ld = 1; lv = 192; rd = 1; rv = 192; end
      default: ;
    endcase
  endfunction

  function automatic int approach(input int d, input int goal);
    int gap;
    gap = (goal > d) ? goal - d : d - goal;
    if (gap > RAMP_STEP) gap = RAMP_STEP;
    return (goal > d) ? d + gap : d - gap;
  endfunction

  always @(posedge clk_50) begin : model_blk
    int ld, lv, rd, rv, pend, braking, nphase, old_l, old_r;
    if (reset) begin
      m_k = 0; m_phase = 0; m_cmd = 0; m_ldir = 1; m_rdir = 1; m_lduty = 0; m_rduty = 0;
      m_lpwm = 0; m_rpwm = 0; m_dead_left = 0; m_valid = 1'b1; m_reset_edge = 1'b1;
    end else begin
      m_reset_edge = 1'b0;
      target_of(m_cmd, m_ldir, m_rdir, ld, lv, rd, rv);
      pend = ((lv > 0 && ld != m_ldir) || (rv > 0 && rd != m_rdir)) ? 1 : 0;
      m_lpwm = (m_phase != 2 && ((m_k / PRESCALE) % 256) < m_lduty) ? 1 : 0;
      m_rpwm = (m_phase != 2 && ((m_k / PRESCALE) % 256) < m_rduty) ? 1 : 0;
      braking = (m_phase != 0 || pend != 0) ? 1 : 0;
      old_l = m_lduty; old_r = m_rduty;
      nphase = m_phase;
      if (m_phase == 0) begin
        if (pend != 0) nphase = 1;
      end else if (m_phase == 1) begin
        if (pend == 0) nphase = 0;
        else if (old_l == 0 && old_r == 0) begin nphase = 2; m_dead_left = DEADTIME; end
      end else begin
        m_dead_left--;
        if (m_dead_left == 0) begin nphase = 0; m_ldir = ld; m_rdir = rd; end
      end
      if (m_k % RAMP_TICK == RAMP_TICK - 1) begin
        m_lduty = approach(old_l, (braking != 0) ? 0 : lv);
        m_rduty = approach(old_r, (braking != 0) ? 0 : rv);
      end
      m_phase = nphase;
      m_cmd = int'(drive_state);
      m_k++;
    end
    target_of(m_cmd, m_ldir, m_rdir, ld, lv, rd, rv);
    m_settled = (m_phase == 0 && m_lduty == lv && m_rduty == rv && m_ldir == ld && m_rdir == rd) ? 1 : 0;
  end

  int p_ldir, p_rdir, p_seq;
  bit p_valid = 1'b0;

  always @(negedge clk_50) begin : compare_blk
    int exp_vec, act_vec;
    if (m_valid) begin
      exp_vec = (m_lpwm << 22) | (m_rpwm << 21) | (m_ldir << 20) | (m_rdir << 19) |
                (m_lduty << 11) | (m_rduty << 3) | (m_phase << 1) | m_settled;
      act_vec = int'({left_pwm, right_pwm, left_dir, right_dir, left_duty, right_duty, seq_state, settled});
      check("cycle_vs_model", act_vec, exp_vec);
      if (p_valid && !m_reset_edge) begin
        if (int'(left_dir) != p_ldir) begin
          check("ldir_flip_pwm", int'(left_pwm), 0);
          check("ldir_flip_duty", int'(left_duty), 0);
          check("ldir_flip_after_dead", p_seq, 2);
        end
        if (int'(right_dir) != p_rdir) begin
          check("rdir_flip_pwm", int'(right_pwm), 0);
          check("rdir_flip_duty", int'(right_duty), 0);
          check("rdir_flip_after_dead", p_seq, 2);
        end
      end
      p_ldir = int'(left_dir); p_rdir = int'(right_dir); p_seq = int'(seq_state); p_valid = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  bit saw_dead, saw_brake;

  task automatic wait_settled(input string name, input int bound);
    saw_dead = 1'b0; saw_brake = 1'b0;
    @(negedge clk_50);
    for (int i = 0; i < bound && !settled; i++) begin
      if (seq_state == 2'b10) saw_dead = 1'b1;
      if (seq_state == 2'b01) saw_brake = 1'b1;
      @(negedge clk_50);
    end
    check(name, int'(settled), 1);
  endtask

  task automatic wait_seq(input string name, input logic [1:0] s, input int bound);
    for (int i = 0; i < bound && seq_state != s; i++) @(negedge clk_50);
    check(name, int'(seq_state), int'(s));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_duties"}, int'({left_duty, right_duty}), 0);
    check({tag, "_dirs"}, int'({left_dir, right_dir}), 3);
    check({tag, "_pwm"}, int'({left_pwm, right_pwm}), 0);
    check({tag, "_seq"}, int'(seq_state), 0);
    check({tag, "_settled"}, int'(settled), 1);
  endtask

  initial begin : main_blk
    int prev, steps, last_i, hl, hr, dead_n, pwm_seen;
    cyc(3);
    check_reset_values("reset");
    reset = 1'b0;
    cyc(5);
    check_reset_values("stop_idle");

    drive_state = 3'b101;
    prev = 0; steps = 0; last_i = 0;
    for (int i = 0; i < 200 && steps < 12; i++) begin
      @(negedge clk_50);
      if (int'(left_duty) != prev) begin
        steps++;
        check("fast_ramp_step", int'(left_duty), prev + 16);
        check("fast_ramp_pair", int'(right_duty), int'(left_duty));
        if (steps > 1) check("fast_ramp_spacing", i - last_i, 4);
        prev = int'(left_duty); last_i = i;
      end
    end
    check("fast_ramp_steps", steps, 12);
    wait_settled("fast_settled", 50);
    check("fast_duty", int'({left_duty, right_duty}), 16'hC0C0);
    hl = 0; hr = 0;
    repeat (256) begin
      @(negedge clk_50);
      hl += int'(left_pwm); hr += int'(right_pwm);
    end
    check("fast_pwm_high_left", hl, 192);
    check("fast_pwm_high_right", hr, 192);

    drive_state = 3'b001;
    wait_seq("left_reach_brake", 2'b01, 10);
    wait_seq("left_reach_dead", 2'b10, 200);
    dead_n = 0; pwm_seen = 0;
    while (seq_state == 2'b10 && dead_n < 40) begin
      dead_n++;
      pwm_seen |= int'(left_pwm | right_pwm);
      @(negedge clk_50);
    end
    check("left_dead_cycles", dead_n, 8);
    check("left_dead_pwm", pwm_seen, 0);
    check("left_dir_flip", int'(left_dir), 0);
    check("right_dir_hold", int'(right_dir), 1);
    wait_settled("left_settled", 100);
    check("left_duty96", int'({left_duty, right_duty}), 16'h6060);

    for (int t = 0; t < 10; t++) begin
      drive_state = (t % 2 == 0) ? 3'b010 : 3'b001;
      cyc(2);
    end
    drive_state = 3'b010;
    wait_settled("toggle_settled", 400);
    check("toggle_final_dirs", int'({left_dir, right_dir}), 2);
    check("toggle_final_duty", int'({left_duty, right_duty}), 16'h6060);

    reset = 1'b1; cyc(1); reset = 1'b0;
    drive_state = 3'b101;
    wait_settled("abort_fast_settled", 200);
    drive_state = 3'b001;
    wait_seq("abort_reach_brake", 2'b01, 10);
    cyc(4);
    drive_state = 3'b011;
    wait_settled("abort_slow_settled", 300);
    check("abort_no_dead", int'(saw_dead), 0);
    check("abort_dirs", int'({left_dir, right_dir}), 3);
    check("abort_duty64", int'({left_duty, right_duty}), 16'h4040);

    drive_state = 3'b100;
    wait_settled("med_settled", 200);
    drive_state = 3'b111;
    wait_settled("code7_settled", 200);
    check("code7_no_brake", int'(saw_brake), 0);
    check("code7_duty0", int'({left_duty, right_duty}), 0);
    drive_state = 3'b001;
    wait_seq("reset_reach_dead", 2'b10, 100);
    cyc(3);
    reset = 1'b1; drive_state = 3'b000;
    cyc(1);
    check_reset_values("reset_in_dead");
    reset = 1'b0;

    for (int n = 0; n < 80; n++) begin
      drive_state = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1; cyc(1); reset = 1'b0;
      end
      cyc((n % 3 == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 60)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/motor_drive_sequencer.md
# motor_drive_sequencer

Converts the 3-bit global drive command (STOP/LEFT/RIGHT/SLOW/MEDIUM/FAST) from the mode FSM into PWM and direction signals for the left and right H-bridges. It sits between the mode FSM's `drive_state` output and the motor driver pins. It ramps duty cycles instead of stepping them, and it sequences every direction reversal as brake-to-zero, dead time, then flip. This keeps shoot-through and current spikes off the bridges when the camera loop toggles LEFT/RIGHT rapidly.

## Interface
- `PRESCALE`, 4 — clk_50 cycles per PWM counter increment; PWM period = 256·PRESCALE cycles.
- `RAMP_TICK`, 50000 — cycles between duty ramp steps (1 ms).
- `RAMP_STEP`, 8 — maximum duty change per ramp step (8-bit units).
- `DEADTIME`, 50000 — cycles both bridges are held off before a direction flip.
- `clk_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `drive_state`  in  3  drive command: 000 STOP, 001 LEFT, 010 RIGHT, 011 SLOW, 100 MEDIUM, 101 FAST; 110/111 are treated as STOP.
- `left_pwm`, `right_pwm`  out  1  bridge enable PWM, registered.
- `left_dir`, `right_dir`  out  1  1 = forward, 0 = reverse.
- `left_duty`, `right_duty`  out  8  current applied duty.
- `seq_state`  out  2  00 RUN, 01 BRAKE, 10 DEAD.
- `settled`  out  1  high when in RUN with both duties equal to their targets and directions matching the command.

## Operation
- Command decode gives target (dir, duty) per motor:
  - STOP: 0 for both motors, direction unchanged.
  - LEFT: L reverse 96, R forward 96.
  - RIGHT: L forward 96, R reverse 96.
  - SLOW: both forward 64.
  - MEDIUM: both forward 128.
  - FAST: both forward 192.
- `drive_state` is registered once (cmd_q); decode uses cmd_q.
- Ramp: a free-running tick counter wraps at RAMP_TICK−1. On each tick, each duty moves toward its effective target by min(RAMP_STEP, |target−duty|).
- RUN:
  - Effective target = decoded target.
  - If either motor's target dir ≠ current dir and its target duty > 0 → go to BRAKE.
- BRAKE:
  - Effective targets are 0 for both motors; ramp down.
  - If cmd_q changes so that no dir mismatch remains → return to RUN without a dead time.
  - When both duties reach 0 → go to DEAD and load the dead-time counter.
- DEAD:
  - Both PWM outputs are forced 0 and duties stay 0.
  - After DEADTIME cycles, latch the target dirs of the current cmd_q → go to RUN.
  - Command changes during DEAD do not shorten the dead time; the latest command's dirs are the ones latched.
- PWM: an 8-bit counter advances every PRESCALE cycles; `x_pwm` = (cnt < x_duty). Duty 0 gives constant 0; duty 255 gives 255/256 high.
- Reset values:
  - duties 0, dirs 1 (forward), pwm 0.
  - seq_state RUN, settled 1 (STOP is the reset command).
  - All counters 0.
- A reset mid-ramp or mid-DEAD clears immediately on the next edge; there is no dead time after reset, because pwm is already 0.

## Timing
- Command to decode: 1 cycle (cmd_q).
- Command to first duty change: ≤ RAMP_TICK+1 cycles.
- Full ramp from 0 to duty D: ceil(D/RAMP_STEP) ticks.
- Reversal latency = ramp-down ticks + DEADTIME + 1 cycle (dir update), followed by ramp-up.
- `x_dir` changes only on the DEAD→RUN edge, and only while duty = 0 and pwm = 0.
- `x_pwm` is registered: 1 cycle after the counter/duty compare.
- STOP never forces BRAKE; it just ramps to 0 in RUN.
- An equal target and duty never overshoot; clamp the final step.

## Structure
- Shared package `drive_pkg`:
  - `drive_state_t` enum (codes as the mode FSM uses).
  - `seq_state_t` enum.
  - Duty constants: DUTY_TURN = 96, DUTY_SLOW = 64, DUTY_MED = 128, DUTY_FAST = 192.
- Sub-module `pwm_gen` (prescaler, 8-bit counter, compare, registered output), instantiated once per motor.
- Ramp, dead-time logic and FSM stay in the top block.

## Test plan
The bench uses PRESCALE=1, RAMP_TICK=4, RAMP_STEP=16, DEADTIME=8.
- Reset, then `drive_state`=000 → duties 0, dirs 1, pwm 0, seq_state RUN, settled 1.
- Apply FAST (101) → both duties step 16, 32 … 192 every 4 cycles (12 ticks), then settled=1. Check the PWM high count = 192 of 256 cycles.
- From FAST, apply LEFT (001):
  - BRAKE: duties ramp 192→0.
  - DEAD: 8 cycles with pwm 0.
  - left_dir → 0, right_dir stays 1, then both ramp to 96.
- LEFT→RIGHT→LEFT toggled every 2 cycles during BRAKE → no dir change until the command is stable. Check that pwm is never 1 while a dir bit changes.
- During BRAKE from FAST toward LEFT, switch to SLOW → return to RUN, no DEAD, duties ramp to 64, dirs unchanged.
- Code 111 from MEDIUM → ramp to 0 as STOP. Then assert `reset` during a DEAD window → next cycle all outputs are at reset values.
